// File: rtl/hex_display_scanner.sv
// rtl/hex_display_scanner.sv - eight-digit multiplexed 7-segment scanner with frame-aligned word commit
// Optional change-blink on commit is built when HEX_SCAN_CHANGE_BLINK_EN is defined.
module hex_display_scanner #(
  parameter int unsigned SCAN_DIV       = 50000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] HexDisplay32Bits,
  input  logic        Load_Valid,
  output logic        Load_Ready,
  input  logic        Blank_Enable,
  output logic [7:0]  Digit_Enable,
  output logic [6:0]  Segments,
  output logic        Frame_Done,
  output logic [31:0] Active_Word
);

  localparam int            PW         = $clog2(SCAN_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [7:0]    DEN_OFF    = SEG_ACTIVE_LOW ? 8'hFF : 8'h00;
  localparam logic [6:0]    SEG_OFF    = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

  logic [PW-1:0] presc_q;
  logic [2:0]    digit_q;
  logic [31:0]   pending_q;
  logic          pending_full_q;
  logic [31:0]   active_q;
  logic [7:0]    den_q;
  logic [6:0]    seg_q;
  logic          frame_done_q;

  logic          terminal;
  logic          boundary;
  logic          commit;
  logic          load_fire;
  logic [31:0]   shifted;
  logic          blank_lz;
  logic          blink_off;
  logic [6:0]    seg_on_d;
  logic [6:0]    seg_d;
  logic [7:0]    den_d;

  assign terminal  = (presc_q == PRESC_LAST);
  assign boundary  = terminal && (digit_q == 3'd7);
  // Commit only drains a full buffer; accept only into an empty one, so the two never coincide.
  assign commit    = boundary && pending_full_q;
  assign load_fire = Load_Valid && !pending_full_q;

  assign Load_Ready   = !pending_full_q;
  assign Digit_Enable = den_q;
  assign Segments     = seg_q;
  assign Frame_Done   = frame_done_q;
  assign Active_Word  = active_q;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef HEX_SCAN_CHANGE_BLINK_EN
  logic [7:0] mask_q;
  logic [5:0] fcnt_q;
  logic [7:0] change_mask;

  always_comb begin
    change_mask = '0;
    for (int i = 0; i < 8; i++) begin
      change_mask[i] = (pending_q[4*i +: 4] != active_q[4*i +: 4]);
    end
  end

  assign blink_off = mask_q[digit_q] && !fcnt_q[5] && fcnt_q[2];

  // Counter advances on the same edge the frame wraps, so frame k after a commit sees count k.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      mask_q <= '0;
      fcnt_q <= '0;
    end else if (commit) begin
      mask_q <= change_mask;
      fcnt_q <= '0;
    end else if (boundary && (mask_q != 8'h00)) begin
      if (fcnt_q == 6'd31) begin
        mask_q <= '0;
        fcnt_q <= 6'd32;
      end else begin
        fcnt_q <= fcnt_q + 6'd1;
      end
    end
  end
`else
  assign blink_off = 1'b0;
`endif

  // Everything above the current nibble, inclusive, being zero means the digit is a leading zero.
  always_comb begin
    shifted  = active_q >> {digit_q, 2'b00};
    blank_lz = Blank_Enable && (digit_q != 3'd0) && (shifted == 32'd0);
    seg_on_d = (blank_lz || blink_off) ? 7'h00 : hex7(shifted[3:0]);
    seg_d    = SEG_ACTIVE_LOW ? ~seg_on_d : seg_on_d;
    den_d    = SEG_ACTIVE_LOW ? ~(8'd1 << digit_q) : (8'd1 << digit_q);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      presc_q        <= '0;
      digit_q        <= '0;
      pending_q      <= '0;
      pending_full_q <= 1'b0;
      active_q       <= '0;
      den_q          <= DEN_OFF;
      seg_q          <= SEG_OFF;
      frame_done_q   <= 1'b0;
    end else begin
      presc_q      <= terminal ? '0 : presc_q + 1'b1;
      if (terminal) begin
        digit_q <= digit_q + 3'd1;
      end
      frame_done_q <= boundary;
      den_q        <= den_d;
      seg_q        <= seg_d;
      if (commit) begin
        active_q       <= pending_q;
        pending_full_q <= 1'b0;
      end else if (load_fire) begin
        pending_q      <= HexDisplay32Bits;
        pending_full_q <= 1'b1;
      end
    end
  end

endmodule

// File: doc/hex_display_scanner.md
Name: hex_display_scanner

Overview:
Consumer end of the 32-bit debug display word driven by the display multiplexer.
- Accepts a new display word through a valid/ready load handshake.
- Holds the word in a pending buffer, then commits it to the active register only at a frame boundary, so a scan never shows a mix of two words.
- Time-multiplexes the eight hex digits onto one shared 7-segment bus, with optional leading-zero blanking.
- Sits between the display mux output and the board's digit/segment pins.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is driven (legal range 2..2^20).
SEG_ACTIVE_LOW, 1, 1: Segments and Digit_Enable are active-low; 0: both are active-high.

Ports:
Clock  in  1  system clock, rising edge
Reset  in  1  synchronous, active-high
HexDisplay32Bits  in  32  word to display; digit i shows bits [4i+3:4i]
Load_Valid  in  1  HexDisplay32Bits is valid this cycle
Load_Ready  out  1  pending buffer is empty; a load is accepted
Blank_Enable  in  1  enables leading-zero blanking
Digit_Enable  out  8  one-hot digit strobe (polarity per SEG_ACTIVE_LOW)
Segments  out  7  {g,f,e,d,c,b,a} (polarity per SEG_ACTIVE_LOW)
Frame_Done  out  1  one-cycle pulse at the end of each 8-digit frame
Active_Word  out  32  word currently being scanned, for debug

Behaviour:
Reset (synchronous, Clock edge with Reset=1):
- Prescaler, digit index and pending flag are cleared to 0; Active_Word = 0.
- Load_Ready = 1, Frame_Done = 0.
- Digit_Enable and Segments are all inactive (0xFF / 0x7F when active-low).
- The first digit is driven on the cycle after Reset deasserts.
- Reset asserted mid-frame or mid-load discards the pending word.

Prescaler and scan:
- Prescaler counts 0..SCAN_DIV-1, then wraps to 0.
- On terminal count, the digit index advances by 1, wrapping 7 -> 0.
- All outputs are registered. Digit_Enable and Segments reflect the current digit index one cycle after it changes.

Load handshake:
- Load_Ready = ~pending_full.
- A transfer occurs when Load_Valid & Load_Ready at a rising edge. The word is captured into the pending buffer and pending_full is set.
- While pending_full = 1, Load_Valid is ignored and HexDisplay32Bits need not be held.

Frame boundary (terminal count with digit index = 7):
- Frame_Done pulses for exactly one cycle.
- If pending_full = 1, the pending word is copied to Active_Word and pending_full clears. Load_Ready is high on the next cycle.
- Simultaneous boundary and handshake: the commit happens, and the new word is accepted into the now-empty buffer one cycle later. A load is never lost and never committed in the same cycle it is accepted.

Segment encoding (hex nibble to segments, active-high form):
- 0 = 3F, 1 = 06, 2 = 5B, 3 = 4F, 4 = 66, 5 = 6D, 6 = 7D, 7 = 07
- 8 = 7F, 9 = 6F, A = 77, b = 7C, C = 39, d = 5E, E = 79, F = 71
- Outputs are inverted when SEG_ACTIVE_LOW = 1.

Leading-zero blanking:
- Digit i (i >= 1) is blanked when Blank_Enable = 1 and Active_Word[31:4i] == 0.
- A blanked digit has its strobe still asserted but all segments off.
- Digit 0 is never blanked.
- Blank_Enable is sampled every cycle (no latching).

Optional Feature:
Macro: HEX_SCAN_CHANGE_BLINK_EN
- Defined:
  - At each commit, an 8-bit change mask is computed: one bit per digit whose nibble differs between the old and new Active_Word.
  - A 6-bit frame counter restarts at 0 and counts Frame_Done pulses.
  - While the counter is < 32, masked digits have segments off whenever counter[2] = 1 (blinks at 8 frames per period).
  - When the counter reaches 32, the mask clears and counting stops.
  - A new commit during an active blink recomputes the mask and restarts the counter.
  - Reset clears the mask and the counter.
- Undefined: no mask or counter logic is generated; output is identical to the blink-inactive case.

Test Plan:
1. Reset, SCAN_DIV=4 -> outputs all off during reset. After release, the Digit_Enable sequence FE,FD,FB,...,7F repeats every 32 cycles. Frame_Done pulses once per 32 cycles.
2. Load 0x12345678 mid-frame -> Load_Ready drops the next cycle. Active_Word stays 0 until the frame boundary, then becomes 0x12345678. Digit 0 shows segments ~7F (8); digit 7 shows ~06 (1).
3. Load_Valid held high with 0xAAAA0000 then 0xBBBB0000 -> the second word is accepted only after the commit of the first. Neither word is dropped. Load_Ready is low for exactly the interval between acceptance and commit.
4. Blank_Enable=1, word 0x000000A0 -> digits 2..7 are blank, digit 1 shows ~77 (A), digit 0 shows ~3F (0). Word 0x00000000 -> only digit 0 lit, showing "0".
5. Reset asserted while pending_full=1 -> pending word discarded, Active_Word = 0, Load_Ready = 1 on the cycle after reset.
6. With HEX_SCAN_CHANGE_BLINK_EN defined, commit 0x00000000 -> 0x000000F0 -> only digit 1 blinks, off during frames 4-7, 12-15, 20-23, 28-31. It is steady from frame 32 on.
